hazard_ctl: RTL
===============

Name: hazard_ctl

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS core.
- Replaces the constant-zero AnyStall with real stall, flush and forward control.
- Holds a scoreboard of in-flight register writes for every post-decode stage, and a busy counter for a multi-cycle multiply/divide unit (MDU).
- Drives fetch/decode stall, the decode-to-execute bubble and the operand-forward selects.

Parameters:
- REG_AW, default 5: register address width.
- PIPE_DEPTH, default 3: number of tracked post-decode stages (EX, ME, WB).
- MDU_LAT, default 4: MDU result latency in cycles; must be ≥1.
- FW, default 2: forward-select width; must be ≥ clog2(PIPE_DEPTH+1).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- Valid_ID  in  1  decode holds a real instruction.
- Rs_ID  in  REG_AW  source A register.
- Rt_ID  in  REG_AW  source B register.
- UsesRs_ID  in  1  instruction reads Rs.
- UsesRt_ID  in  1  instruction reads Rt.
- WriteReg_ID  in  REG_AW  destination register.
- RegWrite_ID  in  1  instruction writes the register file.
- MemToReg_ID  in  1  instruction is a load.
- MduOp_ID  in  1  instruction is an MDU op whose result goes to WriteReg_ID.
- Redirect_EX  in  1  taken branch/jump resolved in EX; decode holds a wrong-path instruction.
- AnyStall  out  1  hold PC and the IF/ID register.
- Flush_ID  out  1  inject a bubble into ID/EX.
- FwdA_ID  out  FW  0 = register file; k = result of scoreboard entry k-1.
- FwdB_ID  out  FW  same encoding as FwdA_ID, for Rt.
- MduBusy  out  1  MDU counter nonzero.

Behaviour:
- Scoreboard:
  - PIPE_DEPTH entries {v, load, dest}; entry 0 is the EX stage and entry PIPE_DEPTH-1 is the oldest.
  - Every cycle, entries shift toward the oldest and the oldest entry is discarded. The pipeline after decode never stalls.
  - Entry 0 loads {Valid_ID & RegWrite_ID & ~MduOp_ID, MemToReg_ID, WriteReg_ID} only if the decode instruction advances, i.e. ~AnyStall & ~Flush_ID & Valid_ID. Otherwise entry 0 loads a bubble (v=0).
- Match for a source S: entry v=1, dest==S, S!=0, and the corresponding UsesRs_ID/UsesRt_ID set.
- Forward select: FwdA_ID/FwdB_ID = 1 + index of the youngest (lowest-index) matching entry, else 0.
- Load-use stall: asserted when entry 0 matches either source and has load=1.
- MDU:
  - On an advancing MduOp: cnt <= MDU_LAT and mdu_dest <= WriteReg_ID.
  - Otherwise cnt decrements while nonzero.
  - MduBusy = (cnt!=0).
- MDU stalls, either condition:
  - MduBusy and MduOp_ID (structural).
  - MduBusy and a used source equals mdu_dest, with mdu_dest!=0 (data).
- AnyStall = Valid_ID & ~Redirect_EX & (load-use | MDU stall).
- Flush_ID = Redirect_EX | AnyStall.
- Priority:
  - Redirect_EX beats every stall: AnyStall=0, and the wrong-path instruction is not recorded.
  - A wrong-path MduOp does not start the counter.
- Simultaneous events:
  - An MDU op advancing in the cycle the counter reaches 0 reloads the counter to MDU_LAT (no gap).
  - Register 0 never forwards and never stalls.
- Combinational outputs are gated:
  - When Valid_ID=0: AnyStall=0 and FwdA_ID/FwdB_ID=0.
  - Flush_ID still follows Redirect_EX.
- Reset, while reset=0 at a clk edge:
  - All entries v=0, cnt=0, mdu_dest=0.
  - While reset is low, all outputs are forced to 0, so the EX/MDU state seen after reset is empty.
  - A reset mid-MDU abandons the operation.
- Timing: no registered outputs. Latency from inputs to AnyStall/Flush/Fwd is zero cycles; the scoreboard updates on the next edge.

Test Plan:
- ALU back-to-back: add r3 then sub r4,r3,r1 (UsesRs) -> cycle 2 FwdA_ID=1, AnyStall=0; with one independent instruction between them, FwdA_ID=2.
- Load-use: lw r5 then add r6,r5,r5 -> exactly 1 cycle AnyStall=1 and Flush_ID=1, then FwdA_ID=FwdB_ID=2, AnyStall=0.
- MDU, MDU_LAT=4: mul r7 then add using r7 -> MduBusy=1 for 4 cycles and AnyStall=1 for those same 4 cycles. Then AnyStall=0. A second mul issued back-to-back also stalls 4 cycles.
- Redirect priority: lw r5 in EX, dependent add in ID, Redirect_EX=1 -> AnyStall=0, Flush_ID=1; next cycle entry 0 v=0, and FwdA_ID=0 for the new instruction.
- r0 and gating: write r0 followed by a reader of r0 -> FwdA_ID=0, AnyStall=0. With UsesRs_ID=0 and a matching Rs -> FwdA_ID=0.
- Reset mid-op: reset low for 1 edge at MDU cnt=2 with entries valid -> outputs 0 during reset; afterwards MduBusy=0 and a dependent reader sees FwdA_ID=0, AnyStall=0.

Source files
------------

// File: rtl/hazard_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctl_if
// Description : Decode-stage hazard request and stall/forward response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctl_if #(
    parameter int REG_AW = 5,
    parameter int FW     = 2
);
    logic              Valid_ID;
    logic [REG_AW-1:0] Rs_ID;
    logic [REG_AW-1:0] Rt_ID;
    logic              UsesRs_ID;
    logic              UsesRt_ID;
    logic [REG_AW-1:0] WriteReg_ID;
    logic              RegWrite_ID;
    logic              MemToReg_ID;
    logic              MduOp_ID;
    logic              Redirect_EX;
    logic              AnyStall;
    logic              Flush_ID;
    logic [FW-1:0]     FwdA_ID;
    logic [FW-1:0]     FwdB_ID;
    logic              MduBusy;

    modport master (
        output Valid_ID, Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, WriteReg_ID,
               RegWrite_ID, MemToReg_ID, MduOp_ID, Redirect_EX,
        input  AnyStall, Flush_ID, FwdA_ID, FwdB_ID, MduBusy
    );

    modport slave (
        input  Valid_ID, Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID, WriteReg_ID,
               RegWrite_ID, MemToReg_ID, MduOp_ID, Redirect_EX,
        output AnyStall, Flush_ID, FwdA_ID, FwdB_ID, MduBusy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctl
// Description : Scoreboard-based stall, flush and forward control with MDU busy tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctl #(
    parameter int REG_AW     = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int MDU_LAT    = 4,
    parameter int FW         = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_ctl_if.slave   bus
);
    localparam int c_CNT_W = $clog2(MDU_LAT + 1);

    logic [PIPE_DEPTH-1:0] r_v;
    logic [PIPE_DEPTH-1:0] r_load;
    logic [REG_AW-1:0]     r_dest [PIPE_DEPTH];
    logic [c_CNT_W-1:0]    r_cnt;
    logic [REG_AW-1:0]     r_mdu_dest;

    logic [PIPE_DEPTH-1:0] w_match_a;
    logic [PIPE_DEPTH-1:0] w_match_b;
    logic [FW-1:0]         w_fwd_a;
    logic [FW-1:0]         w_fwd_b;
    logic                  w_load_use;
    logic                  w_mdu_busy;
    logic                  w_mdu_struct;
    logic                  w_mdu_data;
    logic                  w_stall;
    logic                  w_advance;
    logic                  w_rs_live;
    logic                  w_rt_live;

    // Register 0 is hard-wired, so it can never be a real dependency.
    assign w_rs_live = bus.UsesRs_ID & (bus.Rs_ID != '0);
    assign w_rt_live = bus.UsesRt_ID & (bus.Rt_ID != '0);

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
        assign w_match_a[k] = r_v[k] & w_rs_live & (r_dest[k] == bus.Rs_ID);
        assign w_match_b[k] = r_v[k] & w_rt_live & (r_dest[k] == bus.Rt_ID);
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (w_match_a[k]) w_fwd_a = FW'(k + 1);
            if (w_match_b[k]) w_fwd_b = FW'(k + 1);
        end
    end

    assign w_load_use   = r_load[0] & (w_match_a[0] | w_match_b[0]);
    assign w_mdu_busy   = (r_cnt != '0);
    assign w_mdu_struct = w_mdu_busy & bus.MduOp_ID;
    assign w_mdu_data   = w_mdu_busy & (r_mdu_dest != '0) &
                          ((w_rs_live & (bus.Rs_ID == r_mdu_dest)) |
                           (w_rt_live & (bus.Rt_ID == r_mdu_dest)));
    assign w_stall      = bus.Valid_ID & ~bus.Redirect_EX &
                          (w_load_use | w_mdu_struct | w_mdu_data);
    assign w_advance    = bus.Valid_ID & ~bus.Redirect_EX & ~w_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v        <= '0;
            r_load     <= '0;
            r_cnt      <= '0;
            r_mdu_dest <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) r_dest[k] <= '0;
        end else begin
            r_v[0]    <= w_advance & bus.RegWrite_ID & ~bus.MduOp_ID;
            r_load[0] <= w_advance & bus.MemToReg_ID;
            r_dest[0] <= bus.WriteReg_ID;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_v[k]    <= r_v[k-1];
                r_load[k] <= r_load[k-1];
                r_dest[k] <= r_dest[k-1];
            end
            if (w_advance & bus.MduOp_ID) begin
                r_cnt      <= c_CNT_W'(MDU_LAT);
                r_mdu_dest <= bus.WriteReg_ID;
            end else if (w_mdu_busy) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.AnyStall = reset & w_stall;
    assign bus.Flush_ID = reset & (bus.Redirect_EX | w_stall);
    assign bus.FwdA_ID  = (reset & bus.Valid_ID) ? w_fwd_a : '0;
    assign bus.FwdB_ID  = (reset & bus.Valid_ID) ? w_fwd_b : '0;
    assign bus.MduBusy  = reset & w_mdu_busy;
endmodule
`default_nettype wire
